// File: rtl/adc_pkg.sv
// Shared state type, width constants and lane-packing helper for the ADC frame aligner.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_VERIFY,
        ST_LOCKED,
        ST_FAIL
    } align_state_t;

    localparam int unsigned DEF_SER_W  = 8;
    localparam int unsigned MAX_SER_W  = 32;
    localparam int unsigned DEF_SLIP_W = $clog2(DEF_SER_W) + 1;

    // Operates at the maximum lane width; callers zero-extend and keep the low 2*ser_w bits.
    function automatic logic [2*MAX_SER_W-1:0] pack_lanes(
        input logic [MAX_SER_W-1:0] lane0,
        input logic [MAX_SER_W-1:0] lane1,
        input logic                 interleave,
        input int                   ser_w
    );
        logic [2*MAX_SER_W-1:0] s;
        s = '0;
        if (interleave) begin
            for (int k = 0; k < int'(MAX_SER_W); k++) begin
                if (k < ser_w) begin
                    s[2*k]   = lane0[k];
                    s[2*k+1] = lane1[k];
                end
            end
        end else begin
            s = ({{MAX_SER_W{1'b0}}, lane1} << ser_w) | {{MAX_SER_W{1'b0}}, lane0};
        end
        return s;
    endfunction

endpackage

// File: rtl/adc_frame_aligner_packer.sv
// Per-channel sample packer: registers the packed lane pair, holding while disabled.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int unsigned SER_W      = DEF_SER_W,
    parameter bit          INTERLEAVE = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic [2*SER_W-1:0] lanes_i,
    output logic [2*SER_W-1:0] sample_o
);

    logic [MAX_SER_W-1:0]   lane0_ext;
    logic [MAX_SER_W-1:0]   lane1_ext;
    logic [2*MAX_SER_W-1:0] packed_full;
    logic [2*SER_W-1:0]     sample_d;
    logic [2*SER_W-1:0]     sample_q;
    logic                   unused_pack_hi;

    always_comb begin
        lane0_ext              = '0;
        lane1_ext              = '0;
        lane0_ext[SER_W-1:0]   = lanes_i[SER_W-1:0];
        lane1_ext[SER_W-1:0]   = lanes_i[2*SER_W-1:SER_W];
        packed_full            = pack_lanes(lane0_ext, lane1_ext, INTERLEAVE, int'(SER_W));
        sample_d               = packed_full[2*SER_W-1:0];
    end

    assign unused_pack_hi = ^packed_full[2*MAX_SER_W-1:2*SER_W];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sample_q <= '0;
        end else if (en_i) begin
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/adc_frame_aligner.sv
// Frame alignment FSM (bitslip search, lock confirmation, loss detection) plus per-channel sample packing.
//   state     | meaning
//   IDLE      | disabled, waiting for en
//   CHECK     | compare frame word once
//   SLIP      | bitslip pulse issued this cycle
//   SETTLE    | wait for ISERDES to settle after a slip
//   VERIFY    | counting consecutive frame matches
//   LOCKED    | aligned, watching for consecutive misses
//   FAIL      | all bit positions tried, waiting for realign
module adc_frame_aligner
    import adc_pkg::*;
#(
    parameter int unsigned      NUM_CH        = 4,
    parameter int unsigned      SER_W         = DEF_SER_W,
    parameter logic [SER_W-1:0] FRAME_PATTERN = SER_W'(8'hF0),
    parameter int unsigned      SETTLE_CYCLES = 4,
    parameter int unsigned      LOCK_COUNT    = 16,
    parameter int unsigned      LOSS_THRESH   = 4,
    parameter bit               INTERLEAVE    = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic                          realign_i,
    input  logic [SER_W-1:0]              frame_word_i,
    input  logic [NUM_CH*2*SER_W-1:0]     lane_data_i,
    output logic                          bitslip_o,
    output logic                          aligned_o,
    output logic                          lock_lost_o,
    output logic                          align_err_o,
    output logic [$clog2(SER_W):0]        slip_count_o,
    output logic [NUM_CH*2*SER_W-1:0]     sample_out_o,
    output logic                          sample_valid_o
);

    localparam int unsigned       SLIP_W      = $clog2(SER_W) + 1;
    localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(SER_W - 1);
    localparam logic [7:0]        MATCH_LAST  = 8'(LOCK_COUNT - 1);
    localparam logic [3:0]        MISS_LAST   = 4'(LOSS_THRESH - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    align_state_t      state_q;
    logic [SLIP_W-1:0] slip_cnt_q;
    logic [7:0]        match_cnt_q;
    logic [3:0]        miss_cnt_q;
    logic [3:0]        settle_q;
    logic              bitslip_q;
    logic              aligned_q;
    logic              lock_lost_q;
    logic              align_err_q;
    logic              valid_q;
    logic              frame_match;
    logic              lock_now;

    assign frame_match = (frame_word_i == FRAME_PATTERN);
    // The first match is counted in CHECK, so a single-match lock skips VERIFY.
    assign lock_now    = (state_q == ST_CHECK) ? (MATCH_LAST == 8'd0)
                                               : (match_cnt_q == MATCH_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            settle_q    <= '0;
            bitslip_q   <= 1'b0;
            aligned_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            align_err_q <= 1'b0;
        end else if (!en_i) begin
            state_q     <= ST_IDLE;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            settle_q    <= '0;
            bitslip_q   <= 1'b0;
            aligned_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else if (realign_i) begin
            state_q     <= ST_CHECK;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            settle_q    <= '0;
            bitslip_q   <= 1'b0;
            aligned_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_CHECK;
                    slip_cnt_q <= '0;
                end
                ST_CHECK, ST_VERIFY: begin
                    if (frame_match && lock_now) begin
                        state_q    <= ST_LOCKED;
                        aligned_q  <= 1'b1;
                        miss_cnt_q <= '0;
                    end else if (frame_match) begin
                        state_q     <= ST_VERIFY;
                        match_cnt_q <= (state_q == ST_CHECK) ? 8'd1 : match_cnt_q + 8'd1;
                    end else if (slip_cnt_q >= SLIP_LAST) begin
                        state_q     <= ST_FAIL;
                        align_err_q <= 1'b1;
                    end else begin
                        state_q    <= ST_SLIP;
                        bitslip_q  <= 1'b1;
                        slip_cnt_q <= slip_cnt_q + SLIP_W'(1);
                    end
                end
                ST_SLIP: begin
                    state_q  <= ST_SETTLE;
                    settle_q <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_q == 4'd0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (frame_match) begin
                        miss_cnt_q <= '0;
                    end else if (miss_cnt_q == MISS_LAST) begin
                        state_q     <= ST_CHECK;
                        lock_lost_q <= 1'b1;
                        aligned_q   <= 1'b0;
                        slip_cnt_q  <= '0;
                        miss_cnt_q  <= '0;
                        match_cnt_q <= '0;
                    end else begin
                        miss_cnt_q <= miss_cnt_q + 4'd1;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_FAIL;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= en_i && (state_q == ST_LOCKED);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_sample_packer #(
            .SER_W      (SER_W),
            .INTERLEAVE (INTERLEAVE)
        ) u_pack (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .en_i     (en_i),
            .lanes_i  (lane_data_i[c*2*SER_W +: 2*SER_W]),
            .sample_o (sample_out_o[c*2*SER_W +: 2*SER_W])
        );
    end

    assign bitslip_o      = bitslip_q;
    assign aligned_o      = aligned_q;
    assign lock_lost_o    = lock_lost_q;
    assign align_err_o    = align_err_q;
    assign slip_count_o   = slip_cnt_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Bench for adc_frame_aligner: rotating-frame plant model, directed alignment scenarios, randomized lane data.
module tb_adc_frame_aligner;
    import adc_pkg::*;

    localparam int         NUM_CH = 4;
    localparam int         SER_W  = 8;
    localparam int         SETTLE = 4;
    localparam int         LOCK_N = 16;
    localparam int         DW     = NUM_CH * 2 * SER_W;
    localparam logic [7:0] PAT    = 8'hF0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          realign = 1'b0;
    logic [7:0]    frame_word = 8'h00;
    logic [DW-1:0] lane_data = '0;

    logic                  bitslip_i, aligned_i, lock_lost_i, align_err_i, valid_i;
    logic [DEF_SLIP_W-1:0] slip_i;
    logic [DW-1:0]         sample_i;
    logic                  bitslip_c, aligned_c, lock_lost_c, align_err_c, valid_c;
    logic [DEF_SLIP_W-1:0] slip_c;
    logic [DW-1:0]         sample_c;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int slips = 0;
    int last_slip = -1;
    int rot = 0;
    bit plant_on = 1'b0;

    always #5 clk = ~clk;

    adc_frame_aligner #(.INTERLEAVE(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .realign_i(realign),
        .frame_word_i(frame_word), .lane_data_i(lane_data),
        .bitslip_o(bitslip_i), .aligned_o(aligned_i), .lock_lost_o(lock_lost_i),
        .align_err_o(align_err_i), .slip_count_o(slip_i),
        .sample_out_o(sample_i), .sample_valid_o(valid_i)
    );

    adc_frame_aligner #(.INTERLEAVE(1'b0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .realign_i(realign),
        .frame_word_i(frame_word), .lane_data_i(lane_data),
        .bitslip_o(bitslip_c), .aligned_o(aligned_c), .lock_lost_o(lock_lost_c),
        .align_err_o(align_err_c), .slip_count_o(slip_c),
        .sample_out_o(sample_c), .sample_valid_o(valid_c)
    );

    function automatic logic [7:0] rotl(input logic [7:0] v, input int r);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < r; i++) x = {x[6:0], x[7]};
        return x;
    endfunction

    function automatic logic [15:0] ref_pack(input logic [7:0] l0, input logic [7:0] l1, input bit il);
        logic [15:0] s;
        s = 16'h0;
        if (il) begin
            for (int k = 0; k < 8; k++) begin
                if (l0[k]) s = s | (16'h1 << (2*k));
                if (l1[k]) s = s | (16'h1 << (2*k + 1));
            end
        end else begin
            s = {l1, l0};
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] ref_frame(input logic [DW-1:0] d, input bit il);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c*16 +: 16] = ref_pack(d[c*16 +: 8], d[c*16 + 8 +: 8], il);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the plant rotates the frame right by one bit per observed bitslip.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bitslip_i === 1'b1) begin
            slips++;
            if (last_slip >= 0) chk("slip_spacing", 64'(cyc - last_slip), 64'(SETTLE + 2));
            last_slip = cyc;
            if (plant_on) begin
                rot = (rot + 7) % 8;
                frame_word = rotl(PAT, rot);
            end
        end
    endtask

    task automatic wait_for(input int which, input string tag, input int maxc, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < maxc) begin
            tick();
            n++;
            if ((which == 0 && aligned_i === 1'b1) || (which == 1 && align_err_i === 1'b1) ||
                (which == 2 && bitslip_i === 1'b1)) found = 1'b1;
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL %s_timeout: waited %0d cycles, limit %0d", tag, n, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [7:0]    bad;
        logic [DW-1:0] hold_exp;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_bitslip", 64'(bitslip_i), 64'd0);
        chk("rst_aligned", 64'(aligned_i), 64'd0);
        chk("rst_lock_lost", 64'(lock_lost_i), 64'd0);
        chk("rst_align_err", 64'(align_err_i), 64'd0);
        chk("rst_slip_count", 64'(slip_i), 64'd0);
        chk("rst_sample", 64'(sample_i), 64'd0);
        chk("rst_valid", 64'(valid_i), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Pattern correct from the start
        frame_word = PAT; plant_on = 1'b1; rot = 0; slips = 0; last_slip = -1;
        en = 1'b1;
        wait_for(0, "lock_direct", 60, n);
        chk("lock_direct_latency", 64'(n), 64'(LOCK_N + 1));
        chk("lock_direct_slips", 64'(slips), 64'd0);
        chk("lock_direct_slip_count", 64'(slip_i), 64'd0);
        chk("lock_direct_aligned_c", 64'(aligned_c), 64'd1);

        // Rotated frame: first by 3, then random rotations
        for (int t = 0; t < 4; t++) begin
            r = (t == 0) ? 3 : int'($urandom_range(1, 7));
            rot = r; frame_word = rotl(PAT, rot); slips = 0; last_slip = -1;
            realign = 1'b1; tick(); realign = 1'b0;
            wait_for(0, "lock_rot", 200, n);
            chk("lock_rot_slips", 64'(slips), 64'(r));
            chk("lock_rot_slip_count", 64'(slip_i), 64'(r));
        end

        // Pattern never matches
        plant_on = 1'b0; frame_word = 8'h00; slips = 0; last_slip = -1;
        realign = 1'b1; tick(); realign = 1'b0;
        wait_for(1, "fail", 200, n);
        chk("fail_slips", 64'(slips), 64'(SER_W - 1));
        chk("fail_aligned", 64'(aligned_i), 64'd0);
        chk("fail_slip_count", 64'(slip_i), 64'(SER_W - 1));
        repeat (10) tick();
        chk("fail_hold_err", 64'(align_err_i), 64'd1);
        chk("fail_no_more_slips", 64'(slips), 64'(SER_W - 1));
        frame_word = PAT;
        realign = 1'b1; tick(); realign = 1'b0;
        chk("realign_clears_err", 64'(align_err_i), 64'd0);
        chk("realign_slip_count", 64'(slip_i), 64'd0);
        wait_for(0, "relock", 60, n);
        chk("relock_latency", 64'(n), 64'(LOCK_N));

        // Misses below threshold keep lock
        for (int rep = 0; rep < 3; rep++) begin
            for (int m = 0; m < 3; m++) begin
                bad = 8'($urandom);
                if (bad == PAT) bad = bad ^ 8'h01;
                frame_word = bad;
                tick();
                chk("locked_under_thresh", 64'(aligned_i), 64'd1);
            end
            frame_word = PAT;
            tick();
            chk("locked_after_match", 64'(aligned_i), 64'd1);
        end

        // Four consecutive misses lose lock
        for (int m = 0; m < 4; m++) begin
            frame_word = 8'h3C;
            tick();
            if (m < 3) begin
                chk("loss_pending_aligned", 64'(aligned_i), 64'd1);
                chk("loss_pending_lost", 64'(lock_lost_i), 64'd0);
            end else begin
                chk("loss_aligned", 64'(aligned_i), 64'd0);
                chk("loss_lock_lost", 64'(lock_lost_i), 64'd1);
                chk("loss_slip_count", 64'(slip_i), 64'd0);
            end
        end

        // Drop en during VERIFY
        frame_word = PAT;
        tick();
        slips = 0;
        en = 1'b0;
        tick();
        chk("en_low_aligned", 64'(aligned_i), 64'd0);
        chk("en_low_bitslip", 64'(bitslip_i), 64'd0);
        chk("en_low_lock_lost", 64'(lock_lost_i), 64'd1);
        chk("en_low_slip_count", 64'(slip_i), 64'd0);
        repeat (5) tick();
        chk("en_low_no_slips", 64'(slips), 64'd0);
        chk("en_low_aligned_hold", 64'(aligned_i), 64'd0);
        en = 1'b1;
        wait_for(0, "lock_after_en", 60, n);
        chk("lock_after_en_latency", 64'(n), 64'(LOCK_N + 1));
        chk("lock_lost_sticky", 64'(lock_lost_i), 64'd1);

        // Packing
        lane_data = {$urandom, $urandom};
        lane_data[15:0] = 16'h00FF;
        tick();
        chk("pack_il_ch0", 64'(sample_i[15:0]), 64'h5555);
        chk("pack_cat_ch0", 64'(sample_c[15:0]), 64'h00FF);
        chk("pack_valid", 64'(valid_i), 64'd1);
        chk("pack_valid_c", 64'(valid_c), 64'd1);
        for (int i = 0; i < 20; i++) begin
            lane_data = {$urandom, $urandom};
            tick();
            chk("pack_il_rand", 64'(sample_i), 64'(ref_frame(lane_data, 1'b1)));
            chk("pack_cat_rand", 64'(sample_c), 64'(ref_frame(lane_data, 1'b0)));
        end
        hold_exp = ref_frame(lane_data, 1'b1);
        lane_data = {$urandom, $urandom};
        en = 1'b0;
        tick();
        chk("pack_hold", 64'(sample_i), 64'(hold_exp));
        chk("pack_hold_valid", 64'(valid_i), 64'd0);
        en = 1'b1;
        tick();
        chk("pack_resume", 64'(sample_i), 64'(ref_frame(lane_data, 1'b1)));
        chk("pack_resume_valid", 64'(valid_i), 64'd0);

        // Reset asserted during SETTLE
        wait_for(0, "lock_before_rst", 60, n);
        plant_on = 1'b1; rot = 2; frame_word = rotl(PAT, rot); slips = 0; last_slip = -1;
        wait_for(2, "slip_after_loss", 40, n);
        tick();
        chk("slip_single_cycle", 64'(bitslip_i), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_settle_bitslip", 64'(bitslip_i), 64'd0);
        chk("rst_settle_aligned", 64'(aligned_i), 64'd0);
        chk("rst_settle_lock_lost", 64'(lock_lost_i), 64'd0);
        chk("rst_settle_align_err", 64'(align_err_i), 64'd0);
        chk("rst_settle_slip_count", 64'(slip_i), 64'd0);
        chk("rst_settle_sample", 64'(sample_i), 64'd0);
        chk("rst_settle_valid", 64'(valid_i), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
